// File: rtl/sisc_pkg.sv
// Shared constants for the SISC control unit: FSM state codes, opcodes,
// addressing-mode and ALU-operation encodings.
package sisc_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_START0    = 3'd0;
  localparam state_t ST_START1    = 3'd1;
  localparam state_t ST_FETCH     = 3'd2;
  localparam state_t ST_DECODE    = 3'd3;
  localparam state_t ST_EXECUTE   = 3'd4;
  localparam state_t ST_MEM       = 3'd5;
  localparam state_t ST_WRITEBACK = 3'd6;
  localparam state_t ST_HALT      = 3'd7;

  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_LOD  = 4'd1;
  localparam logic [3:0] OP_STR  = 4'd2;
  localparam logic [3:0] OP_SWP  = 4'd3;
  localparam logic [3:0] OP_BRA  = 4'd4;
  localparam logic [3:0] OP_BRR  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_BNR  = 4'd7;
  localparam logic [3:0] OP_ALU  = 4'd8;
  localparam logic [3:0] OP_HLT  = 4'd15;

  // mm value that selects the immediate operand for ALU instructions
  localparam int AM_IMM = 8;

  // alu_op bit1 = suppress status save, bit0 = immediate operand
  localparam logic [1:0] ALU_OP_DEF = 2'b10;
  localparam logic [1:0] ALU_OP_MEM = 2'b11;

  function automatic logic [1:0] alu_op_enc(input logic no_save, input logic imm);
    return {no_save, imm};
  endfunction

endpackage

// File: rtl/sisc_ctrl_br_eval.sv
// Branch condition evaluation: decides whether a branch opcode is taken
// against the status register and whether its target is PC-relative.
module sisc_br_eval
  import sisc_pkg::*;
#(
  parameter int OPW   = 4,
  parameter int MMW   = 4,
  parameter int STATW = 4
) (
  input  logic [OPW-1:0]   opcode,
  input  logic [MMW-1:0]   mm,
  input  logic [STATW-1:0] stat,
  output logic             taken,
  output logic             relative
);

  logic [3:0] op;
  logic       hit;

  assign op  = 4'(opcode);
  assign hit = |(mm & stat);

  always_comb begin
    taken    = 1'b0;
    relative = 1'b0;
    case (op)
      OP_BRA: taken = hit;
      OP_BRR: begin
        taken    = hit;
        relative = 1'b1;
      end
      OP_BNE: taken = !hit;
      OP_BNR: begin
        taken    = !hit;
        relative = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sisc_ctrl.sv
// SISC multi-cycle control FSM: sequences fetch/decode/execute/mem/writeback,
// evaluates branches, and halts on HLT or on a data-memory timeout.
module sisc_ctrl
  import sisc_pkg::*;
#(
  parameter int OPW     = 4,
  parameter int MMW     = 4,
  parameter int STATW   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic [OPW-1:0]   opcode,
  input  logic [MMW-1:0]   mm,
  input  logic [STATW-1:0] stat,
  input  logic             mem_rdy,
  output logic             rf_we,
  output logic [1:0]       alu_op,
  output logic             wb_sel,
  output logic             ir_load,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             br_sel,
  output logic             pc_rst,
  output logic             mem_req,
  output logic             dm_we,
  output logic             halted,
  output logic             timeout_err
);

  localparam int              CNTW    = $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(TIMEOUT);

  state_t          state_q, state_d;
  logic [CNTW-1:0] wait_cnt_q, wait_cnt_d;
  logic            timeout_err_q, timeout_err_d;

  logic [3:0] op;
  logic       is_alu, is_lod, is_str, is_hlt;
  logic       mem_op, imm_mode;
  logic       br_taken, br_rel;

  assign op       = 4'(opcode);
  assign mem_op   = is_lod | is_str;
  assign imm_mode = (mm == MMW'(AM_IMM));

  always_comb begin
    is_alu = 1'b0;
    is_lod = 1'b0;
    is_str = 1'b0;
    is_hlt = 1'b0;
    case (op)
      OP_ALU:          is_alu = 1'b1;
      OP_LOD:          is_lod = 1'b1;
      OP_STR:          is_str = 1'b1;
      OP_HLT:          is_hlt = 1'b1;
      OP_NOOP, OP_SWP: ;
      default:         ;  // branches are handled by the evaluator; unknown codes act as NOOP
    endcase
  end

  sisc_br_eval #(
    .OPW   (OPW),
    .MMW   (MMW),
    .STATW (STATW)
  ) u_br_eval (
    .opcode   (opcode),
    .mm       (mm),
    .stat     (stat),
    .taken    (br_taken),
    .relative (br_rel)
  );

  // Next-state, wait counter and sticky timeout flag
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      ST_START0:    state_d = ST_START1;
      ST_START1:    state_d = ST_FETCH;
      ST_FETCH:     state_d = ST_DECODE;
      ST_DECODE:    state_d = is_hlt ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE: begin
        state_d    = ST_MEM;
        wait_cnt_d = '0;
      end
      ST_MEM: begin
        // mem_rdy wins over the timeout when both land on the same cycle
        if (!mem_op || mem_rdy) begin
          state_d = ST_WRITEBACK;
        end else if (wait_cnt_q == CNT_MAX) begin
          state_d       = ST_HALT;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNTW'(1);
        end
      end
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_START0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q       <= ST_START0;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    alu_op   = ALU_OP_DEF;
    wb_sel   = 1'b0;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    pc_rst   = 1'b0;
    mem_req  = 1'b0;
    dm_we    = 1'b0;
    halted   = 1'b0;
    case (state_q)
      ST_START0, ST_START1: pc_rst = 1'b1;
      ST_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
      end
      ST_DECODE: begin
        if (br_taken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          br_sel   = br_rel;
        end
      end
      ST_EXECUTE: begin
        if (is_alu)      alu_op = alu_op_enc(1'b0, imm_mode);
        else if (mem_op) alu_op = ALU_OP_MEM;
      end
      ST_MEM: begin
        if (is_alu) begin
          alu_op = alu_op_enc(1'b1, imm_mode);
        end else if (mem_op) begin
          alu_op  = ALU_OP_MEM;
          mem_req = 1'b1;
          dm_we   = is_str;
        end
      end
      ST_WRITEBACK: begin
        rf_we  = is_alu | is_lod;
        wb_sel = is_lod;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign timeout_err = timeout_err_q;

endmodule

// File: doc/sisc_ctrl.md
SISC_CTRL -- requirements
Module: sisc_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- OPW, 4, opcode width.
- MMW, 4, mode/mask field width.
- STATW, 4, status register width; STATW SHALL equal MMW.
- TIMEOUT, 15, maximum MEM wait cycles before fault; TIMEOUT SHALL be at least 1.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock, rising edge.
- rst_f, in, 1, reset, asynchronous, active-low.
- opcode, in, OPW, instr[31:28].
- mm, in, MMW, instr[27:24]: addressing mode / branch mask.
- stat, in, STATW, status register value.
- mem_rdy, in, 1, data memory completes the access this cycle.
- rf_we, out, 1, register file write enable.
- alu_op, out, 2, bit1=1 suppresses status save; bit0=1 selects immediate operand.
- wb_sel, out, 1, 0 selects ALU result, 1 selects memory read data.
- ir_load, out, 1, instruction register load.
- pc_write, out, 1, PC update enable.
- pc_sel, out, 1, 0 selects PC+1, 1 selects branch target.
- br_sel, out, 1, 0 selects absolute target, 1 selects PC-relative target.
- pc_rst, out, 1, PC clear.
- mem_req, out, 1, data memory request.
- dm_we, out, 1, data memory write.
- halted, out, 1, FSM is in HALT.
- timeout_err, out, 1, HALT was entered by memory timeout.

Function
REQ-003 States: START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
REQ-004 Transitions: START0->START1->FETCH->DECODE->EXECUTE->MEM->WRITEBACK->FETCH.
REQ-005 DECODE with opcode=HLT(15) SHALL go to HALT; HALT SHALL persist until reset.
REQ-006 Opcodes: NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU=8, HLT=15; any other value SHALL behave as NOOP.
REQ-007 Default outputs in every state: alu_op=2'b10, all other outputs 0.
REQ-008 START0 and START1: pc_rst=1.
REQ-009 FETCH: ir_load=1, pc_write=1, pc_sel=0.
REQ-010 DECODE, branch evaluation:
- BRA/BRR taken when (mm & stat)!=0.
- BNE/BNR taken when (mm & stat)==0.
- Taken branch: pc_write=1, pc_sel=1; br_sel=1 for BRR/BNR only.
- Not taken: no PC outputs asserted.
REQ-011 EXECUTE:
- ALU: alu_op={0, mm==8}.
- LOD/STR: alu_op=2'b11.
REQ-012 MEM:
- ALU: alu_op={1, mm==8}.
- LOD/STR: alu_op=2'b11, mem_req=1; STR also dm_we=1.
- Stay in MEM while mem_rdy=0.
REQ-013 Wait counter, width clog2(TIMEOUT+1):
- Clears on MEM entry.
- Increments each MEM cycle with mem_rdy=0.
- Reaching TIMEOUT with mem_rdy=0: next state HALT, timeout_err set (sticky).
REQ-014 mem_rdy=1 in the same cycle the counter equals TIMEOUT SHALL complete normally (WRITEBACK); no error.
REQ-015 Opcodes other than LOD/STR SHALL leave MEM after one cycle regardless of mem_rdy.
REQ-016 WRITEBACK:
- rf_we=1 for ALU and LOD; wb_sel=1 for LOD.
- NOOP, STR, branches: rf_we=0.
REQ-017 HALT: halted=1, all other outputs at defaults; timeout_err holds its value.

Reset
REQ-018 rst_f=0 SHALL immediately force START0, clear the wait counter and timeout_err, and drive pc_rst=1 with all other outputs 0 except alu_op=2'b10, including mid-MEM or in HALT.
REQ-019 The first rising clk after rst_f deasserts SHALL move START0->START1.

Structure
REQ-020 Package sisc_pkg SHALL hold the state enumeration, opcode constants, AM_IMM=8 and alu_op encodings.
REQ-021 Branch condition logic SHALL be a sub-module sisc_br_eval (opcode, mm, stat -> taken, relative).

Verification
REQ-022 Reset then ADD (op=8, mm=0): FETCH ir_load=1; EXECUTE alu_op=00; MEM alu_op=10; WRITEBACK rf_we=1, wb_sel=0.
REQ-023 BNE with mm=4'b0001, stat=4'b0000: DECODE pc_write=1, pc_sel=1, br_sel=0; repeat with stat=4'b0001: no PC update.
REQ-024 LOD with mem_rdy low 3 cycles: MEM held 4 cycles with mem_req=1; then WRITEBACK rf_we=1, wb_sel=1.
REQ-025 STR with mem_rdy stuck 0, TIMEOUT=15: after 15 wait cycles halted=1, timeout_err=1; mem_rdy=1 on cycle 15 instead gives WRITEBACK, no error.
REQ-026 HLT: halted=1 persists 20 cycles; rst_f pulsed low mid-MEM of a STR: START0 immediately, timeout_err=0.
